// File: rtl/dragonfang_pkg.sv
// Platform-wide vector configuration.
package dragonfang_pkg;

  localparam int unsigned VLEN = 128;

endpackage

// File: rtl/riscv_v_pkg.sv
// RISC-V vector types shared between the decoder and the mask execute units.
package riscv_v_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    POPC  = 3'd0,
    FIRST = 3'd1,
    SBF   = 3'd2,
    SIF   = 3'd3,
    SOF   = 3'd4
  } mask_reduction_op_t;

endpackage

// File: rtl/mask_chunk_scanner.sv
// Combinational scan of one mask chunk: popcount, first set bit and set-first masks.
module mask_chunk_scanner #(
  parameter int unsigned CHUNK_WIDTH = 16
) (
  input  logic [CHUNK_WIDTH-1:0]         src,
  input  logic [CHUNK_WIDTH-1:0]         act,
  input  logic                           found_in,
  output logic [$clog2(CHUNK_WIDTH):0]   pop_c,
  output logic [$clog2(CHUNK_WIDTH)-1:0] first_c,
  output logic                           hit_c,
  output logic [CHUNK_WIDTH-1:0]         sbf_c,
  output logic [CHUNK_WIDTH-1:0]         sif_c,
  output logic [CHUNK_WIDTH-1:0]         sof_c
);

  localparam int unsigned PW = $clog2(CHUNK_WIDTH) + 1;
  localparam int unsigned FW = $clog2(CHUNK_WIDTH);

  logic seen;
  logic eff;

  // Walk the chunk low to high; 'seen' tracks whether a set bit precedes element i
  always_comb begin
    pop_c   = '0;
    first_c = '0;
    hit_c   = 1'b0;
    sbf_c   = '0;
    sif_c   = '0;
    sof_c   = '0;
    seen    = found_in;
    eff     = 1'b0;
    for (int i = 0; i < int'(CHUNK_WIDTH); i++) begin
      eff   = src[i] & act[i];
      pop_c = pop_c + PW'(eff);
      if (eff && !hit_c) begin
        first_c = FW'(i);
        hit_c   = 1'b1;
      end
      if (act[i]) begin
        sbf_c[i] = !seen && !eff;
        sif_c[i] = !seen;
        sof_c[i] = !seen && eff;
      end
      if (eff) seen = 1'b1;
    end
  end

endmodule

// File: rtl/vector_mask_reduction_unit.sv
// Multi-cycle RVV mask reduction unit: vcpop.m, vfirst.m, vmsbf.m, vmsif.m, vmsof.m.
module vector_mask_reduction_unit
  import riscv_v_pkg::*;
#(
  parameter int unsigned VLEN        = dragonfang_pkg::VLEN,
  parameter int unsigned CHUNK_WIDTH = 16,
  parameter int unsigned XLEN        = riscv_v_pkg::XLEN
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  mask_reduction_op_t       op,
  input  logic [$clog2(VLEN):0]    vl,
  input  logic                     vm,
  input  logic [VLEN-1:0]          vs2,
  input  logic [VLEN-1:0]          v0,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          rd,
  output logic [VLEN-1:0]          vd
);

  localparam int unsigned NCH = VLEN / CHUNK_WIDTH;
  localparam int unsigned KW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned IW  = $clog2(VLEN);
  localparam int unsigned VLW = IW + 1;
  localparam int unsigned CFW = $clog2(CHUNK_WIDTH);
  localparam int unsigned CPW = $clog2(CHUNK_WIDTH) + 1;

  // FINAL registers the result so out_valid and rd/vd change together
  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_FINAL, ST_DONE} state_t;

  state_t             state;
  logic [KW-1:0]      k;
  logic [KW-1:0]      last_k;
  mask_reduction_op_t op_q;
  logic [VLW-1:0]     vl_q;
  logic               vm_q;
  logic [VLEN-1:0]    vs2_q;
  logic [VLEN-1:0]    v0_q;
  logic [XLEN-1:0]    pop_count;
  logic               found;
  logic [IW-1:0]      first_idx;
  logic [VLEN-1:0]    vd_acc;

  logic [IW-1:0]          base_c;
  logic [IW-1:0]          eidx_c;
  logic [CHUNK_WIDTH-1:0] src_c;
  logic [CHUNK_WIDTH-1:0] act_c;
  logic [CHUNK_WIDTH-1:0] chunk_bits_c;
  logic [CPW-1:0]         pop_c;
  logic [CFW-1:0]         first_c;
  logic                   hit_c;
  logic [CHUNK_WIDTH-1:0] sbf_c;
  logic [CHUNK_WIDTH-1:0] sif_c;
  logic [CHUNK_WIDTH-1:0] sof_c;

  // Slice the current chunk and derive the per-element active mask
  always_comb begin
    base_c = IW'(k * CHUNK_WIDTH);
    src_c  = vs2_q[base_c +: CHUNK_WIDTH];
    act_c  = '0;
    eidx_c = '0;
    for (int j = 0; j < int'(CHUNK_WIDTH); j++) begin
      eidx_c   = base_c + IW'(j);
      act_c[j] = (VLW'(eidx_c) < vl_q) && (vm_q || v0_q[eidx_c]);
    end
  end

  mask_chunk_scanner #(
    .CHUNK_WIDTH (CHUNK_WIDTH)
  ) u_scanner (
    .src      (src_c),
    .act      (act_c),
    .found_in (found),
    .pop_c    (pop_c),
    .first_c  (first_c),
    .hit_c    (hit_c),
    .sbf_c    (sbf_c),
    .sif_c    (sif_c),
    .sof_c    (sof_c)
  );

  // Pick which set-first flavour is written into vd
  always_comb begin
    chunk_bits_c = '0;
    case (op_q)
      SBF:     chunk_bits_c = sbf_c;
      SIF:     chunk_bits_c = sif_c;
      SOF:     chunk_bits_c = sof_c;
      default: chunk_bits_c = '0;
    endcase
  end

  // Control FSM, capture registers, accumulators and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      k         <= '0;
      last_k    <= '0;
      op_q      <= POPC;
      vl_q      <= '0;
      vm_q      <= 1'b0;
      vs2_q     <= '0;
      v0_q      <= '0;
      pop_count <= '0;
      found     <= 1'b0;
      first_idx <= '0;
      vd_acc    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      rd        <= '0;
      vd        <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_q      <= op;
            vl_q      <= vl;
            vm_q      <= vm;
            vs2_q     <= vs2;
            v0_q      <= v0;
            k         <= '0;
            last_k    <= (vl == '0) ? '0 : KW'((32'(vl) - 32'd1) / CHUNK_WIDTH);
            pop_count <= '0;
            found     <= 1'b0;
            first_idx <= '0;
            vd_acc    <= '0;
            in_ready  <= 1'b0;
            state     <= (vl == '0) ? ST_FINAL : ST_SCAN;
          end
        end
        ST_SCAN: begin
          pop_count <= pop_count + XLEN'(pop_c);
          if (!found && hit_c) begin
            found     <= 1'b1;
            first_idx <= base_c + IW'(first_c);
          end
          vd_acc[base_c +: CHUNK_WIDTH] <= chunk_bits_c;
          k <= k + KW'(1);
          if (k == last_k) state <= ST_FINAL;
        end
        ST_FINAL: begin
          rd <= '0;
          vd <= '0;
          case (op_q)
            POPC:  rd <= pop_count;
            FIRST: rd <= found ? XLEN'(first_idx) : '1;
            default: vd <= vd_acc;
          endcase
          out_valid <= 1'b1;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vector_mask_reduction_unit.sv
// Directed self-checking bench for vector_mask_reduction_unit (VLEN=128, CHUNK_WIDTH=16).
module tb_vector_mask_reduction_unit;
  import riscv_v_pkg::*;

  localparam int unsigned VLEN = 128;

  logic               clock = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  mask_reduction_op_t op;
  logic [7:0]         vl;
  logic               vm;
  logic [VLEN-1:0]    vs2;
  logic [VLEN-1:0]    v0;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        rd;
  logic [VLEN-1:0]    vd;

  int tests = 0;
  int fails = 0;

  logic [VLEN-1:0] pat;

  vector_mask_reduction_unit dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .vl        (vl),
    .vm        (vm),
    .vs2       (vs2),
    .v0        (v0),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .rd        (rd),
    .vd        (vd)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present a request for one edge, then count cycles until out_valid (-1 on timeout)
  task automatic run_req(input mask_reduction_op_t r_op, input logic [7:0] r_vl,
                         input logic r_vm, input logic [VLEN-1:0] r_vs2,
                         input logic [VLEN-1:0] r_v0, output int lat);
    in_valid = 1'b1;
    op       = r_op;
    vl       = r_vl;
    vm       = r_vm;
    vs2      = r_vs2;
    v0       = r_v0;
    tick();
    in_valid = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (out_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic accept();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    tests++; if (rd !== 32'd0) begin fails++; $display("FAIL reset_rd got %h want 0", rd); end
    tests++; if (vd !== '0) begin fails++; $display("FAIL reset_vd got %h want 0", vd); end
  endtask

  task automatic test_popc();
    int lat;
    run_req(POPC, 8'd128, 1'b1, pat, '0, lat);
    tests++; if (lat !== 9) begin fails++; $display("FAIL popc_latency got %0d want 9", lat); end
    tests++; if (rd !== 32'd2) begin fails++; $display("FAIL popc_rd got %0d want 2", rd); end
    tests++; if (vd !== '0) begin fails++; $display("FAIL popc_vd got %h want 0", vd); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL popc_in_ready_busy got %0b want 0", in_ready); end
    accept();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL popc_handshake got %0b want 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL popc_in_ready_back got %0b want 1", in_ready); end
  endtask

  task automatic test_first();
    int lat;
    logic [VLEN-1:0] msk;
    run_req(FIRST, 8'd128, 1'b1, pat, '0, lat);
    tests++; if (rd !== 32'd5) begin fails++; $display("FAIL first_rd got %0d want 5", rd); end
    accept();
    msk = '1;
    msk[5] = 1'b0;
    run_req(FIRST, 8'd128, 1'b0, pat, msk, lat);
    tests++; if (rd !== 32'd40) begin fails++; $display("FAIL first_masked_rd got %0d want 40", rd); end
    accept();
  endtask

  task automatic test_set_first();
    int lat;
    run_req(SBF, 8'd128, 1'b1, pat, '0, lat);
    tests++; if (vd !== 128'h1F) begin fails++; $display("FAIL sbf_vd got %h want 1f", vd); end
    tests++; if (rd !== 32'd0) begin fails++; $display("FAIL sbf_rd got %h want 0", rd); end
    accept();
    run_req(SIF, 8'd128, 1'b1, pat, '0, lat);
    tests++; if (vd !== 128'h3F) begin fails++; $display("FAIL sif_vd got %h want 3f", vd); end
    tests++; if (rd !== 32'd0) begin fails++; $display("FAIL sif_rd got %h want 0", rd); end
    accept();
    run_req(SOF, 8'd128, 1'b1, pat, '0, lat);
    tests++; if (vd !== 128'h20) begin fails++; $display("FAIL sof_vd got %h want 20", vd); end
    tests++; if (rd !== 32'd0) begin fails++; $display("FAIL sof_rd got %h want 0", rd); end
    accept();
  endtask

  task automatic test_short_vl();
    int lat;
    logic [VLEN-1:0] s;
    s = '0;
    s[5] = 1'b1;
    run_req(FIRST, 8'd3, 1'b1, s, '0, lat);
    tests++; if (lat !== 2) begin fails++; $display("FAIL short_first_latency got %0d want 2", lat); end
    tests++; if (rd !== 32'hFFFF_FFFF) begin fails++; $display("FAIL short_first_rd got %h want ffffffff", rd); end
    accept();
    run_req(SBF, 8'd3, 1'b1, s, '0, lat);
    tests++; if (vd !== 128'h7) begin fails++; $display("FAIL short_sbf_vd got %h want 7", vd); end
    accept();
  endtask

  task automatic test_zero_vl_and_busy();
    int lat;
    run_req(POPC, 8'd0, 1'b1, pat, '0, lat);
    tests++; if (lat !== 1) begin fails++; $display("FAIL vl0_latency got %0d want 1", lat); end
    tests++; if (rd !== 32'd0) begin fails++; $display("FAIL vl0_rd got %0d want 0", rd); end
    accept();
    // Start a POPC, then pulse a FIRST request mid-scan; it must be dropped
    in_valid = 1'b1; op = POPC; vl = 8'd128; vm = 1'b1; vs2 = pat; v0 = '0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL busy_in_ready got %0b want 0", in_ready); end
    in_valid = 1'b1; op = FIRST; vl = 8'd3; vs2 = '1;
    tick();
    in_valid = 1'b0;
    lat = -1;
    for (int c = 4; c <= 40; c++) begin
      tick();
      if (out_valid) begin
        lat = c;
        break;
      end
    end
    tests++; if (lat !== 9) begin fails++; $display("FAIL busy_latency got %0d want 9", lat); end
    tests++; if (rd !== 32'd2) begin fails++; $display("FAIL busy_rd got %0d want 2", rd); end
    accept();
  endtask

  task automatic test_backpressure();
    int lat;
    run_req(SIF, 8'd128, 1'b1, pat, '0, lat);
    for (int c = 0; c < 5; c++) begin
      tick();
      tests++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        fails++; $display("FAIL bp_hold cycle %0d got valid=%0b ready=%0b want 1/0", c, out_valid, in_ready);
      end
      tests++; if (vd !== 128'h3F || rd !== 32'd0) begin
        fails++; $display("FAIL bp_stable cycle %0d got vd=%h rd=%h want 3f/0", c, vd, rd);
      end
    end
    accept();
  endtask

  task automatic test_reset_mid_scan();
    int lat;
    in_valid = 1'b1; op = POPC; vl = 8'd128; vm = 1'b1; vs2 = pat; v0 = '0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_out_valid got %0b want 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_in_ready got %0b want 1", in_ready); end
    tests++; if (rd !== 32'd0) begin fails++; $display("FAIL rst_mid_rd got %h want 0", rd); end
    tests++; if (vd !== '0) begin fails++; $display("FAIL rst_mid_vd got %h want 0", vd); end
    run_req(POPC, 8'd128, 1'b1, pat, '0, lat);
    tests++; if (lat !== 9 || rd !== 32'd2) begin
      fails++; $display("FAIL rst_recover got lat=%0d rd=%0d want 9/2", lat, rd);
    end
    accept();
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    op        = POPC;
    vl        = '0;
    vm        = 1'b1;
    vs2       = '0;
    v0        = '0;
    out_ready = 1'b0;
    pat       = '0;
    pat[5]    = 1'b1;
    pat[40]   = 1'b1;
    test_reset();
    test_popc();
    test_first();
    test_set_first();
    test_short_vl();
    test_zero_vl_and_busy();
    test_backpressure();
    test_reset_mid_scan();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
